// File: rtl/utpu_pkg.sv
// Shared uTPU control-path types and instruction field positions.
// Instruction layout: [15:6] addr, [5:3] flags, [2:0] opcode.
package utpu_pkg;

  localparam int unsigned OPC_W    = 3;
  localparam int unsigned FLAG_W   = 3;
  localparam int unsigned OPC_LSB  = 0;
  localparam int unsigned FLAG_LSB = 3;
  localparam int unsigned ADDR_LSB = 6;

  typedef enum logic [OPC_W-1:0] {
    OP_STORE = 3'd0,
    OP_FETCH = 3'd1,
    OP_RUN   = 3'd2,
    OP_LOAD  = 3'd3,
    OP_HALT  = 3'd4,
    OP_NOP   = 3'd5,
    OP_ILL6  = 3'd6,
    OP_ILL7  = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH_LO = 3'd1,
    S_FETCH_HI = 3'd2,
    S_DECODE   = 3'd3,
    S_DATA_LO  = 3'd4,
    S_DATA_HI  = 3'd5,
    S_ISSUE    = 3'd6,
    S_HALT     = 3'd7
  } seq_state_e;

endpackage

// File: rtl/byte_word_assembler.sv
// Builds a two-byte word from a byte stream; i_hi_sel picks which half a
// write lands in. The other half is left untouched, so a stalled stream
// never disturbs an already captured byte.
// Ports: i_clk, i_rst_n (async active-low), i_clr (zero both halves),
//        i_we/i_hi_sel/i_byte (byte write), o_word ({hi, lo}).
module byte_word_assembler #(
  parameter int unsigned BYTE_W = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clr,
  input  logic                  i_we,
  input  logic                  i_hi_sel,
  input  logic [BYTE_W-1:0]     i_byte,
  output logic [2*BYTE_W-1:0]   o_word
);

  logic [BYTE_W-1:0] r_lo;
  logic [BYTE_W-1:0] r_hi;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lo <= '0;
      r_hi <= '0;
    end else if (i_clr) begin
      r_lo <= '0;
      r_hi <= '0;
    end else if (i_we) begin
      if (i_hi_sel) r_hi <= i_byte;
      else          r_lo <= i_byte;
    end
  end

  assign o_word = {r_hi, r_lo};

endmodule

// File: rtl/instr_sequencer.sv
// uTPU instruction sequencer: pops 16-bit instructions (low byte first) from
// the receive FIFO, fetches a data word for STORE, issues one command at a
// time to the datapath and waits for cmd_done (with timeout).
// Ports: i_clk, i_rst_n (async active-low), i_start (leave IDLE),
//        i_rx_empty/i_rx_data (FWFT FIFO head), o_rx_re_c (pop strobe),
//        o_cmd_valid/op/flags/addr/data (command), i_cmd_done (completion),
//        o_busy, o_halted, o_err (sticky), o_instr_count (retired ops).
module instr_sequencer
  import utpu_pkg::*;
#(
  parameter int unsigned FIFO_DATA_WIDTH = 8,
  parameter int unsigned INSTR_WIDTH     = 16,
  parameter int unsigned OPCODE_WIDTH    = 3,
  parameter int unsigned ADDRESS_SIZE    = 10,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  input  logic                       i_rx_empty,
  input  logic [FIFO_DATA_WIDTH-1:0] i_rx_data,
  output logic                       o_rx_re_c,
  output logic                       o_cmd_valid,
  output logic [OPCODE_WIDTH-1:0]    o_cmd_op,
  output logic [FLAG_W-1:0]          o_cmd_flags,
  output logic [ADDRESS_SIZE-1:0]    o_cmd_addr,
  output logic [INSTR_WIDTH-1:0]     o_cmd_data,
  input  logic                       i_cmd_done,
  output logic                       o_busy,
  output logic                       o_halted,
  output logic                       o_err,
  output logic [15:0]                o_instr_count
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  seq_state_e                r_state;
  seq_state_e                w_next_state;
  logic                      r_cmd_valid;
  logic [OPCODE_WIDTH-1:0]   r_cmd_op;
  logic [FLAG_W-1:0]         r_cmd_flags;
  logic [ADDRESS_SIZE-1:0]   r_cmd_addr;
  logic                      r_busy;
  logic                      r_halted;
  logic                      r_err;
  logic [15:0]               r_instr_count;
  logic [TMO_W-1:0]          r_tmo_cnt;

  logic                      w_instr_we;
  logic                      w_data_we;
  logic                      w_data_clr;
  logic                      w_hi_sel;
  logic                      w_rx_re;
  logic                      w_retire;
  logic                      w_set_err;
  logic                      w_load_cmd;
  logic                      w_tmo_hit;
  logic [INSTR_WIDTH-1:0]    w_instr;
  logic [INSTR_WIDTH-1:0]    w_data_word;
  logic [OPC_W-1:0]          w_opc;
  opcode_e                   w_op;

  // Instruction word and STORE data word share the same assembler design.
  byte_word_assembler #(.BYTE_W(FIFO_DATA_WIDTH)) u_instr_asm (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (1'b0),
    .i_we     (w_instr_we),
    .i_hi_sel (w_hi_sel),
    .i_byte   (i_rx_data),
    .o_word   (w_instr)
  );

  byte_word_assembler #(.BYTE_W(FIFO_DATA_WIDTH)) u_data_asm (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (w_data_clr),
    .i_we     (w_data_we),
    .i_hi_sel (w_hi_sel),
    .i_byte   (i_rx_data),
    .o_word   (w_data_word)
  );

  assign w_opc     = w_instr[OPC_LSB +: OPC_W];
  assign w_op      = opcode_e'(w_opc);
  // Last ISSUE cycle before timeout: counter starts at 0 on the first cycle.
  assign w_tmo_hit = (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    w_next_state = r_state;
    w_rx_re      = 1'b0;
    w_instr_we   = 1'b0;
    w_data_we    = 1'b0;
    w_data_clr   = 1'b0;
    w_hi_sel     = 1'b0;
    w_retire     = 1'b0;
    w_set_err    = 1'b0;
    w_load_cmd   = 1'b0;
    case (r_state)
      S_IDLE: if (i_start) w_next_state = S_FETCH_LO;
      S_FETCH_LO: if (!i_rx_empty) begin
        w_rx_re      = 1'b1;
        w_instr_we   = 1'b1;
        w_next_state = S_FETCH_HI;
      end
      S_FETCH_HI: if (!i_rx_empty) begin
        w_rx_re      = 1'b1;
        w_instr_we   = 1'b1;
        w_hi_sel     = 1'b1;
        w_next_state = S_DECODE;
      end
      S_DECODE: begin
        // Non-STORE commands must present cmd_data = 0.
        w_data_clr = 1'b1;
        case (w_op)
          OP_STORE: w_next_state = S_DATA_LO;
          OP_FETCH, OP_RUN, OP_LOAD: begin
            w_load_cmd   = 1'b1;
            w_next_state = S_ISSUE;
          end
          OP_NOP: begin
            w_retire     = 1'b1;
            w_next_state = S_FETCH_LO;
          end
          OP_HALT: begin
            w_retire     = 1'b1;
            w_next_state = S_HALT;
          end
          default: begin
            w_set_err    = 1'b1;
            w_next_state = S_HALT;
          end
        endcase
      end
      S_DATA_LO: if (!i_rx_empty) begin
        w_rx_re      = 1'b1;
        w_data_we    = 1'b1;
        w_next_state = S_DATA_HI;
      end
      S_DATA_HI: if (!i_rx_empty) begin
        w_rx_re      = 1'b1;
        w_data_we    = 1'b1;
        w_hi_sel     = 1'b1;
        w_load_cmd   = 1'b1;
        w_next_state = S_ISSUE;
      end
      S_ISSUE: begin
        // cmd_done takes priority over a simultaneous timeout.
        if (i_cmd_done) begin
          w_retire     = 1'b1;
          w_next_state = S_FETCH_LO;
        end else if (w_tmo_hit) begin
          w_set_err    = 1'b1;
          w_next_state = S_HALT;
        end
      end
      S_HALT: w_next_state = S_HALT;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Registered outputs, command fields, counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cmd_valid   <= 1'b0;
      r_cmd_op      <= '0;
      r_cmd_flags   <= '0;
      r_cmd_addr    <= '0;
      r_busy        <= 1'b0;
      r_halted      <= 1'b0;
      r_err         <= 1'b0;
      r_instr_count <= '0;
      r_tmo_cnt     <= '0;
    end else begin
      r_cmd_valid <= (w_next_state == S_ISSUE);
      r_busy      <= (w_next_state != S_IDLE) && (w_next_state != S_HALT);
      r_halted    <= (w_next_state == S_HALT);
      if (w_set_err) r_err <= 1'b1;
      if (w_retire)  r_instr_count <= r_instr_count + 16'd1;
      if (r_state == S_ISSUE) r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      else                    r_tmo_cnt <= '0;
      if (w_load_cmd) begin
        r_cmd_op    <= OPCODE_WIDTH'(w_opc);
        r_cmd_flags <= w_instr[FLAG_LSB +: FLAG_W];
        r_cmd_addr  <= w_instr[ADDR_LSB +: ADDRESS_SIZE];
      end
    end
  end

  assign o_rx_re_c     = w_rx_re;
  assign o_cmd_valid   = r_cmd_valid;
  assign o_cmd_op      = r_cmd_op;
  assign o_cmd_flags   = r_cmd_flags;
  assign o_cmd_addr    = r_cmd_addr;
  assign o_cmd_data    = w_data_word;
  assign o_busy        = r_busy;
  assign o_halted      = r_halted;
  assign o_err         = r_err;
  assign o_instr_count = r_instr_count;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: a queue models the FWFT receive FIFO, a vector
// table drives single-instruction transactions, and hand-written sequences
// cover stalls, illegal opcodes, timeout and asynchronous reset.
module tb_instr_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        rx_empty;
  logic [7:0]  rx_data;
  logic        rx_re;
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic [2:0]  cmd_flags;
  logic [9:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic        cmd_done;
  logic        busy;
  logic        halted;
  logic        err;
  logic [15:0] instr_count;

  logic [7:0]  fq[$];
  logic        last_re;
  logic        any_re;
  logic [15:0] exp_cnt;
  int          n_tests;
  int          n_fail;

  typedef struct {
    logic [7:0]  b0, b1, d0, d1;
    logic        has_data;
    int          lat;
    int          dly;
    logic        exp_valid;
    logic [2:0]  op;
    logic [2:0]  fl;
    logic [9:0]  addr;
    logic [15:0] data;
  } vec_t;

  vec_t vecs[7];

  instr_sequencer dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_rx_empty    (rx_empty),
    .i_rx_data     (rx_data),
    .o_rx_re_c     (rx_re),
    .o_cmd_valid   (cmd_valid),
    .o_cmd_op      (cmd_op),
    .o_cmd_flags   (cmd_flags),
    .o_cmd_addr    (cmd_addr),
    .o_cmd_data    (cmd_data),
    .i_cmd_done    (cmd_done),
    .o_busy        (busy),
    .o_halted      (halted),
    .o_err         (err),
    .o_instr_count (instr_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle, entered and left at a falling edge. FIFO head is
  // presented first; a pop seen by the DUT is taken off the queue.
  task automatic step();
    rx_empty = (fq.size() == 0);
    rx_data  = (fq.size() != 0) ? fq[0] : 8'h00;
    #1;
    last_re = rx_re;
    if (rx_re) begin
      any_re = 1'b1;
      void'(fq.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    start    = 1'b0;
    cmd_done = 1'b0;
    fq.delete();
    rx_empty = 1'b1;
    rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_rx_re"},  32'(rx_re),       32'd0);
    chk({p, "_valid"},  32'(cmd_valid),   32'd0);
    chk({p, "_op"},     32'(cmd_op),      32'd0);
    chk({p, "_flags"},  32'(cmd_flags),   32'd0);
    chk({p, "_addr"},   32'(cmd_addr),    32'd0);
    chk({p, "_data"},   32'(cmd_data),    32'd0);
    chk({p, "_busy"},   32'(busy),        32'd0);
    chk({p, "_halted"}, 32'(halted),      32'd0);
    chk({p, "_err"},    32'(err),         32'd0);
    chk({p, "_count"},  32'(instr_count), 32'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    last_re = 1'b0;
    any_re  = 1'b0;
    exp_cnt = 16'd0;

    //          b0     b1     d0     d1    data lat dly vld  op    fl      addr     data
    vecs[0] = '{8'h82, 8'h01, 8'h00, 8'h00, 1'b0, 3, 2, 1'b1, 3'd2, 3'b000, 10'h006, 16'h0000}; // RUN
    vecs[1] = '{8'h08, 8'h00, 8'hCD, 8'hAB, 1'b1, 5, 0, 1'b1, 3'd0, 3'b001, 10'h000, 16'hABCD}; // STORE
    vecs[2] = '{8'hC9, 8'hFF, 8'h00, 8'h00, 1'b0, 3, 1, 1'b1, 3'd1, 3'b001, 10'h3FF, 16'h0000}; // FETCH
    vecs[3] = '{8'h7A, 8'h55, 8'h00, 8'h00, 1'b0, 3, 3, 1'b1, 3'd2, 3'b111, 10'h155, 16'h0000}; // RUN all flags
    vecs[4] = '{8'h8B, 8'hAA, 8'h00, 8'h00, 1'b0, 3, 0, 1'b1, 3'd3, 3'b001, 10'h2AA, 16'h0000}; // LOAD
    vecs[5] = '{8'h05, 8'h00, 8'h00, 8'h00, 1'b0, 3, 0, 1'b0, 3'd5, 3'b000, 10'h000, 16'h0000}; // NOP
    vecs[6] = '{8'h40, 8'h00, 8'h34, 8'h12, 1'b1, 5, 1, 1'b1, 3'd0, 3'b000, 10'h001, 16'h1234}; // STORE

    do_reset();
    chk_zero("reset");
    pulse_start();
    chk("start_busy", 32'(busy), 32'd1);

    // Table-driven single-instruction transactions.
    for (int i = 0; i < 7; i++) begin
      fq.push_back(vecs[i].b0);
      fq.push_back(vecs[i].b1);
      if (vecs[i].has_data) begin
        fq.push_back(vecs[i].d0);
        fq.push_back(vecs[i].d1);
      end
      repeat (vecs[i].lat - 1) step();
      chk($sformatf("v%0d_valid_early", i), 32'(cmd_valid), 32'd0);
      step();
      chk($sformatf("v%0d_valid", i), 32'(cmd_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        repeat (vecs[i].dly) step();
        chk($sformatf("v%0d_hold", i),  32'(cmd_valid), 32'd1);
        chk($sformatf("v%0d_op", i),    32'(cmd_op),    32'(vecs[i].op));
        chk($sformatf("v%0d_flags", i), 32'(cmd_flags), 32'(vecs[i].fl));
        chk($sformatf("v%0d_addr", i),  32'(cmd_addr),  32'(vecs[i].addr));
        chk($sformatf("v%0d_data", i),  32'(cmd_data),  32'(vecs[i].data));
        cmd_done = 1'b1;
        step();
        cmd_done = 1'b0;
        chk($sformatf("v%0d_drop", i), 32'(cmd_valid), 32'd0);
      end
      exp_cnt = exp_cnt + 16'd1;
      chk($sformatf("v%0d_count", i), 32'(instr_count), 32'(exp_cnt));
      chk($sformatf("v%0d_busy", i),  32'(busy),        32'd1);
    end

    // FIFO runs dry between low and high byte for 4 cycles.
    fq.push_back(8'h82);
    step();
    chk("stall_pop_lo", 32'(last_re), 32'd1);
    any_re = 1'b0;
    repeat (4) step();
    chk("stall_no_pop", 32'(any_re), 32'd0);
    fq.push_back(8'h01);
    step();
    chk("stall_pop_hi", 32'(last_re), 32'd1);
    step();
    step();
    chk("stall_valid", 32'(cmd_valid), 32'd1);
    chk("stall_op",    32'(cmd_op),    32'd2);
    chk("stall_addr",  32'(cmd_addr),  32'h006);
    cmd_done = 1'b1;
    step();
    cmd_done = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    chk("stall_count", 32'(instr_count), 32'(exp_cnt));

    // Illegal opcode 7 halts with error; later start and bytes are ignored.
    fq.push_back(8'h07);
    fq.push_back(8'h00);
    repeat (3) step();
    chk("ill_halted", 32'(halted),      32'd1);
    chk("ill_err",    32'(err),         32'd1);
    chk("ill_valid",  32'(cmd_valid),   32'd0);
    chk("ill_busy",   32'(busy),        32'd0);
    chk("ill_count",  32'(instr_count), 32'(exp_cnt));
    fq.push_back(8'h82);
    fq.push_back(8'h01);
    any_re = 1'b0;
    pulse_start();
    repeat (3) step();
    chk("ill_no_pop",   32'(any_re), 32'd0);
    chk("ill_stay",     32'(halted), 32'd1);
    chk("ill_no_valid", 32'(cmd_valid), 32'd0);

    // LOAD with cmd_done never asserted times out after 1024 ISSUE cycles.
    do_reset();
    pulse_start();
    fq.push_back(8'h03);
    fq.push_back(8'h00);
    repeat (3) step();
    chk("tmo_valid", 32'(cmd_valid), 32'd1);
    repeat (1023) step();
    chk("tmo_pre_valid",  32'(cmd_valid), 32'd1);
    chk("tmo_pre_halted", 32'(halted),    32'd0);
    step();
    chk("tmo_halted", 32'(halted),      32'd1);
    chk("tmo_err",    32'(err),         32'd1);
    chk("tmo_valid0", 32'(cmd_valid),   32'd0);
    chk("tmo_count",  32'(instr_count), 32'd0);

    // cmd_done in ISSUE cycle 1024 wins over the timeout.
    do_reset();
    pulse_start();
    fq.push_back(8'h03);
    fq.push_back(8'h00);
    repeat (3) step();
    repeat (1023) step();
    cmd_done = 1'b1;
    step();
    cmd_done = 1'b0;
    chk("late_err",    32'(err),         32'd0);
    chk("late_halted", 32'(halted),      32'd0);
    chk("late_valid",  32'(cmd_valid),   32'd0);
    chk("late_count",  32'(instr_count), 32'd1);
    chk("late_busy",   32'(busy),        32'd1);

    // Asynchronous reset while a command is presented.
    fq.push_back(8'h82);
    fq.push_back(8'h01);
    repeat (3) step();
    chk("arst_pre_valid", 32'(cmd_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_zero("arst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    fq.delete();
    fq.push_back(8'h82);
    fq.push_back(8'h01);
    any_re = 1'b0;
    repeat (3) step();
    chk("arst_idle_pop",  32'(any_re),    32'd0);
    chk("arst_idle_busy", 32'(busy),      32'd0);
    pulse_start();
    repeat (3) step();
    chk("arst_run_valid", 32'(cmd_valid), 32'd1);
    chk("arst_run_addr",  32'(cmd_addr),  32'h006);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
